// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4 memory slave backing the CPU's external memory port with a 32-bit word
// array. It serves fetches, loads, stores and page-table walks. INCR bursts
// and byte strobes are supported. RD_LAT/WR_LAT stretch the response timing
// to emulate slow memory. Only one transaction is in flight at a time, and
// both channels share a single-port array.
//
// Handshake rule (all five channels): a transfer happens on the rising clock
// edge where VALID and READY are both high. A source holds VALID and its
// payload stable until that edge. This slave never waits on the master's
// VALID before raising its own VALID.
//
// Ports:
//   clock, reset             clock; asynchronous active-low reset
//   ar* / r*                 read address and read data channels
//   aw* / w* / b*            write address, write data, write response
//   dbg_state                current FSM state, for debug and checkers
//
// Responses: 2'b00 OKAY, 2'b10 SLVERR (size != 4 bytes), 2'b11 DECERR
// (beat address outside [BASE, BASE+4*DEPTH)). DECERR outranks SLVERR.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [2:0]  dbg_state
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] LIMIT     = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
  localparam logic [15:0] RD_RELOAD = 16'(RD_LAT - 1);
  localparam logic [15:0] WR_RELOAD = 16'(WR_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RWAIT = 3'd1,
    S_RBEAT = 3'd2,
    S_WDATA = 3'd3,
    S_WWAIT = 3'd4,
    S_WRESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] cnt_q, cnt_d;
  logic        size_err_q, size_err_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  logic             aw_hs, ar_hs, r_hs, w_hs, b_hs;
  logic             beat_last, dec_err, rd_fetch, wr_en;
  logic [1:0]       beat_resp;
  logic [IDX_W-1:0] word_idx;

  // Every burst is treated as INCR, so the burst type is never consulted.
  logic unused_burst;
  assign unused_burst = ^{arburst, awburst};

  assign aw_hs = awvalid && awready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  assign beat_last = (beat_q == len_q);

  // The range check runs on every beat against the advancing address. A
  // burst that runs off the top of the array errors per beat and never
  // wraps to word 0.
  assign dec_err   = (addr_q < BASE) || ({1'b0, addr_q} >= LIMIT);
  assign beat_resp = dec_err ? 2'b11 : (size_err_q ? 2'b10 : 2'b00);
  assign word_idx  = IDX_W'((addr_q - BASE) >> 2);
  assign wr_en     = w_hs && (beat_resp == 2'b00);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs)      state_d = S_WDATA;
        else if (ar_hs) state_d = S_RWAIT;
      end
      S_RWAIT: if (cnt_q == '0) state_d = S_RBEAT;
      S_RBEAT: if (r_hs) state_d = beat_last ? S_IDLE : S_RWAIT;
      // An early wlast ends the burst. A missing wlast on the final beat is
      // ignored, so the burst still ends.
      S_WDATA: if (w_hs && (wlast || beat_last)) state_d = S_WWAIT;
      S_WWAIT: if (cnt_q == '0) state_d = S_WRESP;
      S_WRESP: if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    rlast   = 1'b0;
    case (state_q)
      // Writes win a same-cycle collision so that store drain never starves.
      // Both readies are gated by reset so they read 0 while reset is held.
      S_IDLE: begin
        awready = reset;
        arready = reset && !awvalid;
      end
      S_RBEAT: begin
        rvalid = 1'b1;
        rlast  = beat_last;
      end
      S_WDATA: wready = 1'b1;
      S_WRESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign bresp     = bresp_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    size_err_d = size_err_q;
    bresp_d    = bresp_q;
    rresp_d    = rresp_q;
    rd_fetch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          addr_d     = awaddr;
          len_d      = awlen;
          size_err_d = (awsize != 3'b010);
          beat_d     = '0;
          bresp_d    = 2'b00;
        end else if (ar_hs) begin
          addr_d     = araddr;
          len_d      = arlen;
          size_err_d = (arsize != 3'b010);
          beat_d     = '0;
          cnt_d      = RD_RELOAD;
        end
      end
      S_RWAIT: begin
        if (cnt_q == '0) begin
          rd_fetch = 1'b1;
          rresp_d  = beat_resp;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RBEAT: begin
        if (r_hs && !beat_last) begin
          addr_d = addr_q + 32'd4;
          beat_d = beat_q + 8'd1;
          cnt_d  = RD_RELOAD;
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          // The encodings are ordered 11 > 10 > 00, so keeping the larger
          // value lets DECERR outrank SLVERR, which outranks OKAY.
          if (beat_resp > bresp_q) bresp_d = beat_resp;
          addr_d = addr_q + 32'd4;
          beat_d = beat_q + 8'd1;
          if (wlast || beat_last) cnt_d = WR_RELOAD;
        end
      end
      S_WWAIT: if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
      S_WRESP: if (b_hs) bresp_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      size_err_q <= 1'b0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      size_err_q <= size_err_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      // Registered array read. Error beats return zero data.
      if (rd_fetch) rdata_q <= (beat_resp == 2'b00) ? mem[word_idx] : 32'h0;
    end
  end

  // The array has no reset. Byte lanes are written only on in-range,
  // correctly sized beats.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed bench for axi_sram_slave. Driver tasks issue AXI transactions. A
// word-level memory model predicts read data and write responses. Expected R
// beats and B responses are queued when stimulus is issued and popped as the
// DUT answers.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [2:0]  dbg_state;

  axi_sram_slave #(
    .BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [34:0] exp_q[$];            // {rdata, rresp, rlast} per R beat
  logic [1:0]  exp_b_q[$];          // bresp per write burst
  logic [31:0] model [logic [31:0]];
  logic [31:0] wdat [8];
  logic [3:0]  wstb [8];
  int          first_lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(DEPTH * 4)));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic void push_read_exp(input logic [31:0] addr, input int len,
                                        input logic [2:0] size);
    logic [31:0] a;
    logic        last;
    for (int i = 0; i <= len; i++) begin
      a    = addr + 32'(4 * i);
      last = (i == len);
      if (!in_range(a))         exp_q.push_back({32'h0, 2'b11, last});
      else if (size != 3'b010)  exp_q.push_back({32'h0, 2'b10, last});
      else exp_q.push_back({(model.exists(a) ? model[a] : 32'h0), 2'b00, last});
    end
  endfunction

  // Predicts bresp and updates the model for a write of len+1 beats.
  function automatic void model_write(input logic [31:0] addr, input int len,
                                      input logic [2:0] size);
    logic [31:0] a;
    logic [1:0]  resp;
    resp = 2'b00;
    for (int i = 0; i <= len; i++) begin
      a = addr + 32'(4 * i);
      if (!in_range(a)) resp = 2'b11;
      else if (size != 3'b010) begin
        if (resp == 2'b00) resp = 2'b10;
      end else model[a] = merge(model.exists(a) ? model[a] : 32'h0, wdat[i], wstb[i]);
    end
    exp_b_q.push_back(resp);
  endfunction

  // ---------------------------------------------------------------- drivers
  // Every phase task starts and ends #1 after a rising edge.
  task automatic ar_phase(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input bit raise);
    int g;
    if (raise) begin
      @(posedge clock); #1;
      araddr = addr; arlen = 8'(len); arsize = size; arburst = 2'b01; arvalid = 1'b1;
    end
    g = 0;
    do begin @(negedge clock); g++; end while (!arready && g < 100);
    if (!arready) check("ar_timeout", 0, 1);
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic r_phase(input int len, input bit bp);
    int          beat, g;
    logic [34:0] cur, held, exp;
    bit          have_held;
    beat = 0; g = 0; have_held = 0; first_lat = -1;
    rready = 1'b1;
    while (beat <= len && g < 200) begin
      @(negedge clock); g++;
      if (rvalid) begin
        if (first_lat < 0) first_lat = g;
        cur = {rdata, rresp, rlast};
        if (have_held) check("r_hold", cur, held);
        if (rready) begin
          have_held = 0;
          if (exp_q.size() == 0) check("r_unexpected", 1, 0);
          else begin
            exp = exp_q.pop_front();
            check("r_beat", cur, exp);
          end
          beat++;
        end else begin
          held = cur; have_held = 1;
        end
      end
      @(posedge clock); #1;
      if (bp && rvalid) rready = ~rready;
    end
    if (beat <= len) check("r_timeout", beat, len + 1);
    rready = 1'b1;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input int len, input logic [2:0] size);
    int g;
    @(posedge clock); #1;
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = 2'b01; awvalid = 1'b1;
    g = 0;
    do begin @(negedge clock); g++; end while (!awready && g < 100);
    if (!awready) check("aw_timeout", 0, 1);
    @(posedge clock); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input int nbeats, input int last_at);
    int g;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == last_at); wvalid = 1'b1;
      g = 0;
      do begin @(negedge clock); g++; end while (!wready && g < 100);
      if (!wready) check("w_timeout", 0, 1);
      @(posedge clock); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase();
    int         g;
    logic [1:0] exp;
    bready = 1'b1;
    g = 0;
    do begin @(negedge clock); g++; end while (!bvalid && g < 100);
    if (!bvalid) check("b_timeout", 0, 1);
    else if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
    else begin
      exp = exp_b_q.pop_front();
      check("bresp", bresp, exp);
    end
    @(posedge clock); #1;
    bready = 1'b0;
    @(negedge clock);
    check("b_cleared", {bvalid, bresp}, 3'b000);
    @(posedge clock); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size);
    model_write(addr, len, size);
    aw_phase(addr, len, size);
    w_phase(len + 1, len);
    b_phase();
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input bit bp);
    push_read_exp(addr, len, size);
    ar_phase(addr, len, size, 1'b1);
    r_phase(len, bp);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int nbeat, g;

    // Reset values.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {arready, awready, wready}, 3'b000);
    check("rst_valid", {rvalid, bvalid, rlast}, 3'b000);
    check("rst_data", {rdata, rresp, bresp}, 36'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Single read of a preloaded word, with latency check.
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
    do_write(BASE, 0, 3'b010);
    do_read(BASE, 0, 3'b010, 1'b0);
    check("rd_latency", first_lat, RD_LAT + 1);

    // Strobed write onto a zeroed word, then read back.
    wdat[0] = 32'h0; wstb[0] = 4'hF;
    do_write(BASE + 32'h10, 0, 3'b010);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
    do_write(BASE + 32'h10, 0, 3'b010);
    do_read(BASE + 32'h10, 0, 3'b010, 1'b0);

    // Burst refill of words 0x40..0x43 under rready backpressure.
    for (int i = 0; i < 4; i++) begin
      wdat[i] = $urandom; wstb[i] = 4'hF;
    end
    do_write(BASE + 32'h100, 3, 3'b010);
    do_read(BASE + 32'h100, 3, 3'b010, 1'b1);

    // Decode errors: below BASE, and a write running off the top of the array.
    do_read(32'h7FFF_FFFC, 0, 3'b010, 1'b0);
    wdat[0] = $urandom; wstb[0] = 4'hF;
    wdat[1] = $urandom; wstb[1] = 4'hF;
    do_write(BASE + 32'(4 * DEPTH) - 32'd4, 1, 3'b010);
    do_read(BASE + 32'(4 * DEPTH) - 32'd4, 1, 3'b010, 1'b0);
    do_read(BASE, 0, 3'b010, 1'b0);

    // Bad size answers SLVERR and leaves the array untouched.
    do_read(BASE, 0, 3'b001, 1'b0);
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    do_write(BASE + 32'h10, 0, 3'b000);
    do_read(BASE + 32'h10, 0, 3'b010, 1'b0);

    // Early wlast ends a 4-beat burst after 2 beats.
    wdat[0] = $urandom; wstb[0] = 4'hF;
    wdat[1] = $urandom; wstb[1] = 4'hF;
    model_write(BASE + 32'h200, 1, 3'b010);
    aw_phase(BASE + 32'h200, 3, 3'b010);
    w_phase(2, 1);
    b_phase();
    do_read(BASE + 32'h200, 1, 3'b010, 1'b0);

    // Collision: the write wins, and the held read sees the new data.
    wdat[0] = $urandom_range(1, 32'hFFFF_FFFF); wstb[0] = 4'hF;
    model_write(BASE + 32'h40, 0, 3'b010);
    @(posedge clock); #1;
    awaddr = BASE + 32'h40; awlen = 8'd0; awsize = 3'b010; awvalid = 1'b1;
    araddr = BASE + 32'h40; arlen = 8'd0; arsize = 3'b010; arvalid = 1'b1;
    @(negedge clock);
    check("coll_ready", {awready, arready}, 2'b10);
    @(posedge clock); #1;
    awvalid = 1'b0;
    w_phase(1, 0);
    @(negedge clock);
    check("coll_ar_blocked", arready, 1'b0);
    @(posedge clock); #1;
    b_phase();
    push_read_exp(BASE + 32'h40, 0, 3'b010);
    ar_phase(BASE + 32'h40, 0, 3'b010, 1'b0);
    r_phase(0, 1'b0);

    // Reset asserted during beat 2 of a 4-beat read.
    push_read_exp(BASE + 32'h100, 3, 3'b010);
    ar_phase(BASE + 32'h100, 3, 3'b010, 1'b1);
    rready = 1'b1;
    nbeat = 0; g = 0;
    while (nbeat < 2 && g < 100) begin
      @(negedge clock); g++;
      if (rvalid) begin
        nbeat++;
        if (nbeat == 1) begin
          void'(exp_q.pop_front());
          check("mid_beat1", {rdata, rresp, rlast}, {model[BASE + 32'h100], 2'b00, 1'b0});
        end
      end
      if (nbeat < 2) begin @(posedge clock); #1; end
    end
    check("mid_reached_beat2", nbeat, 2);
    #1 reset = 1'b0; arvalid = 1'b1;
    #1 check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_arready", arready, 1'b0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clock);
      check("mid_rst_hold", {arready, rvalid}, 2'b00);
    end
    arvalid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_quiet", {rvalid, bvalid}, 2'b00);
    end
    @(posedge clock); #1;
    do_read(BASE + 32'h100, 1, 3'b010, 1'b0);
    check("post_rst_latency", first_lat, RD_LAT + 1);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_b_q_empty", exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 memory slave that consumes the CPU's single external memory port, which is driven by the memory arbiter and the EXU write path.
- Backs the port with a 32-bit-wide word array, serving instruction fetches, loads, stores and MMU page-table walks.
- Supports INCR bursts (ICache refill) and byte strobes, with programmable read latency to emulate slow memory.
- One transaction in flight at a time; the read and write channels share a single-port array.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words; must be a power of two.
- RD_LAT, 2, cycles from acceptance (or previous beat) to each R beat; must be ≥1.
- WR_LAT, 1, cycles from last W beat to B valid; must be ≥1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- araddr  in  32  read address.
- arlen  in  8  beats−1.
- arsize  in  3  must be 3'b010; other values answer SLVERR.
- arburst  in  2  01=INCR; others treated as INCR.
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rlast  out  1  final read beat.
- rvalid  out  1  R valid.
- rready  in  1  R ready.
- awaddr  in  32  write address.
- awlen  in  8  write beats−1.
- awsize  in  3  as arsize.
- awburst  in  2  as arburst.
- awvalid  in  1  AW valid.
- awready  out  1  AW ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  final write beat.
- wvalid  in  1  W valid.
- wready  out  1  W ready.
- bresp  out  2  write response.
- bvalid  out  1  B valid.
- bready  in  1  B ready.

Behaviour:
- Reset (reset=0, async): state=IDLE; counters=0.
  - Outputs at reset: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rdata=0, rresp=0, bresp=0.
  - Array contents are not reset.
  - Reset asserted mid-burst abandons the burst immediately; no partial B or R is issued afterwards.
- States: IDLE, RWAIT, RBEAT, WDATA, WWAIT, WRESP.
- IDLE:
  - arready=1 and awready=1 combinationally in IDLE only.
  - If awvalid && arvalid in the same cycle, the write wins: only awready is asserted; arready=0 that cycle.
  - Channel priority favours stores so that EXU store drain never starves.
  - AW handshake: latch addr, len and err; go to WDATA.
  - AR handshake: latch the same fields; load the latency counter with RD_LAT−1; go to RWAIT.
- Address decoding:
  - word index = (addr−BASE)>>2, truncated to log2(DEPTH) bits.
  - err = (addr<BASE) || (addr ≥ BASE+4·DEPTH) || size≠3'b010.
  - Burst address increments by 4 per beat and is compared again each beat.
  - A burst crossing the top of the array errors only on the out-of-range beats.
  - No wrap-around to word 0.
- RWAIT: decrement the counter. At 0, read the array (registered, 1-cycle) and go to RBEAT.
- RBEAT:
  - Beat outputs: rvalid=1; rdata=array word, or 0 if err; rresp=2'b00 OKAY, 2'b11 DECERR on out-of-range, 2'b10 SLVERR on bad size; rlast=(beat==len).
  - rdata, rresp and rlast hold stable until rready.
  - On handshake: if last, go to IDLE; else advance addr, reload the counter with RD_LAT−1, go to RWAIT.
  - Consequence: with RD_LAT=1, beats stream one every 2 cycles.
- WDATA:
  - wready=1.
  - On handshake, write wdata bytes where wstrb=1 to the array if the beat is in range; drop the write on error.
  - Accumulate the error into bresp: DECERR takes precedence over SLVERR, SLVERR over OKAY.
  - Advance addr.
  - If wlast or beat==len, load the counter with WR_LAT−1 and go to WWAIT.
  - wlast asserted early ends the burst; wlast missing at beat==len is ignored and the burst still ends.
  - W beats offered before AW are not accepted; wready=0 outside WDATA.
- WWAIT: count down to 0, then go to WRESP.
- WRESP: bvalid=1 with the accumulated bresp held until bready; then go to IDLE with bresp cleared.
- A read issued on the cycle after a B handshake returns the updated data (read-after-write coherent).
- Idle-to-first-beat latency: AR handshake at cycle 0, rvalid at cycle RD_LAT+1.

Test Plan:
- Single read:
  - Stimulus: preload word 0 = 32'hDEADBEEF; AR araddr=8000_0000, arlen=0.
  - Required: rvalid at cycle 3 (RD_LAT=2); rdata=DEADBEEF, rresp=00, rlast=1.
- Write then read:
  - Stimulus: AW 8000_0010 len 0, W wdata=1122_3344 wstrb=4'b0101 onto a zeroed word; then AR to the same address.
  - Required: bresp=00; read returns 0022_0044.
- Burst refill with backpressure:
  - Stimulus: arlen=3 at 8000_0100; rready toggles 1,0,1,0.
  - Required: four beats of words 0x40–0x43 in order; rlast only on beat 4; data held stable while rready=0.
- Decode error:
  - Stimulus: AR 7FFF_FFFC; separately, AW at BASE+4·DEPTH−4 with len=1.
  - Required: read gives rresp=11, rdata=0; write updates the last word only; bresp=11.
- Collision:
  - Stimulus: awvalid and arvalid asserted in the same cycle.
  - Required: write accepted first, arready=0; read accepted in IDLE after bready; read returns the new data.
- Reset mid-burst:
  - Stimulus: drop reset during beat 2 of a 4-beat read.
  - Required: rvalid=0 within the same cycle, arready=0 while reset=0; next read after release behaves normally.
